// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and defaults for the FIFO read-side blocks.
//   occ_state_t     - skid buffer occupancy state (EMPTY/ONE/TWO)
//   FIFO_W_DEF      - default data word width
//   CNT_W_DEF       - default accepted-word counter width
//   occ_count()     - numeric occupancy of an occ_state_t
package fifo_pkg;

  localparam int FIFO_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  // State encoding equals the occupancy, so this is a plain cast.
  function automatic logic [1:0] occ_count(input occ_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: bundles the FIFO read port and the output valid/ready stream.
//   fifo_empty, fifo_data : FIFO empty flag and data_out (data valid the cycle after a read)
//   read_enable           : FIFO read strobe
//   m_valid, m_ready, m_data : output stream
//   words_read            : count of words accepted on the output
// Modports: master = the reader block, slave = FIFO + consumer side.
interface fifo_reader_if #(
  parameter int FIFO_W = fifo_pkg::FIFO_W_DEF,
  parameter int CNT_W  = fifo_pkg::CNT_W_DEF
) ();

  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_data;
  logic              read_enable;
  logic              m_valid;
  logic              m_ready;
  logic [FIFO_W-1:0] m_data;
  logic [CNT_W-1:0]  words_read;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output read_enable, m_valid, m_data, words_read
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  read_enable, m_valid, m_data, words_read
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry ordered buffer between FIFO data_out and the stream.
//   clk, rst   : clock, async active-low reset
//   push       : capture push_data into the tail entry this edge
//   push_data  : word to capture
//   pop        : head word consumed this edge
//   head_data  : head entry (oldest word)
//   valid      : buffer non-empty
//   state      : occupancy state
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int FIFO_W = FIFO_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FIFO_W-1:0] push_data,
  input  logic              pop,
  output logic [FIFO_W-1:0] head_data,
  output logic              valid,
  output occ_state_t        state
);

  logic [FIFO_W-1:0] e0;  // head
  logic [FIFO_W-1:0] e1;  // second entry

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            e0    <= push_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            e0 <= push_data;  // captured word becomes the new head
          end else if (push) begin
            e1    <= push_data;
            state <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // push without pop cannot happen here: the read gate keeps
          // occupancy plus the in-flight word at or below two.
          if (pop) begin
            e0 <= e1;
            if (push) e1 <= push_data;
            else      state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign head_data = e0;
  assign valid     = (state != EMPTY);

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a synchronous FIFO and re-presents its words on a
// valid/ready stream, hiding the FIFO's one-cycle read latency.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fifo_reader_if.master (FIFO read port + output stream + words_read)
// Build option: define FIFO_READER_CNT_EN to build the words_read counter;
// otherwise words_read is tied to 0 and no counter flops exist.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int FIFO_W = FIFO_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fifo_reader_if.master bus
);

  logic              inflight;
  logic              pop;
  logic              valid;
  logic [FIFO_W-1:0] head_data;
  occ_state_t        state;
  logic [2:0]        pending;

  assign pop = valid && bus.m_ready;

  // Words that will be held after this edge if nothing new is read. A read
  // is only allowed when that leaves room, so occ + inflight never exceeds 2.
  assign pending = {1'b0, occ_count(state)} + {2'b0, inflight} - {2'b0, pop};

  assign bus.read_enable = rst && !bus.fifo_empty && (pending <= 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inflight <= 1'b0;
    else      inflight <= bus.read_enable;
  end

  fifo_reader_skid #(.FIFO_W(FIFO_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.fifo_data),
    .pop       (pop),
    .head_data (head_data),
    .valid     (valid),
    .state     (state)
  );

  assign bus.m_valid = valid;
  assign bus.m_data  = head_data;

`ifdef FIFO_READER_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (pop) cnt <= cnt + 1'b1;  // wraps modulo 2^CNT_W
  end

  assign bus.words_read = cnt;
`else
  assign bus.words_read = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: randomized self-checking bench for fifo_reader.
// The FIFO is a queue; the reference model tracks the cycle of every FIFO read
// and the word it returned, and derives expected m_valid/read_enable/m_data/
// words_read from the two-cycle latency, ordering and two-slot rules.
module tb_fifo_reader;

  localparam int FW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_reader_if #(.FIFO_W(FW), .CNT_W(CW)) bus ();

  fifo_reader #(.FIFO_W(FW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: data_out updates the edge after a sampled read.
  logic [FW-1:0] fq[$];
  always @(posedge clk)
    if (rst && bus.read_enable && fq.size() > 0) bus.fifo_data <= fq.pop_front();

  // Reference model state
  int            cyc_n = 0;
  int            reads = 0;
  int            pops  = 0;
  int            rd_cyc[$];
  logic [FW-1:0] rd_words[$];
  logic          prev_hold = 1'b0;
  logic [FW-1:0] prev_data = '0;

  function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef FIFO_READER_CNT_EN
    return CW'(n);
`else
    return '0;
`endif
  endfunction

  always @(negedge clk) begin
    logic exp_v, exp_pop, exp_re;
    cyc_n++;
    if (!rst) begin
      chk("rst_read_enable", bus.read_enable, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_words_read", bus.words_read, 0);
      reads = 0;
      pops  = 0;
      rd_cyc.delete();
      rd_words.delete();
      prev_hold = 1'b0;
    end else begin
      // a word is presentable two cycles after its read
      exp_v   = (rd_cyc.size() > pops) && (rd_cyc[pops] <= cyc_n - 2);
      exp_pop = exp_v && bus.m_ready;
      exp_re  = !bus.fifo_empty && ((reads - pops - (exp_pop ? 1 : 0)) <= 1);
      chk("m_valid", bus.m_valid, exp_v);
      chk("read_enable", bus.read_enable, exp_re);
      if (exp_pop) chk("m_data_order", bus.m_data, rd_words[pops]);
      if (prev_hold) chk("m_data_hold", bus.m_data, prev_data);
      chk("words_read", bus.words_read, exp_cnt(pops));
      if (bus.read_enable && fq.size() > 0) begin
        rd_cyc.push_back(cyc_n);
        rd_words.push_back(fq[0]);
        reads++;
      end
      if (exp_pop) pops++;
      chk("occ_plus_inflight_le2", (reads - pops) <= 2, 1);
      prev_hold = exp_v && !bus.m_ready;
      prev_data = bus.m_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.fifo_empty = (fq.size() == 0);
    end
  endtask

  task automatic push(input logic [FW-1:0] w);
    fq.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic drain_until(input string tag, input int target, input int budget, input bit alt_ready);
    int n;
    n = 0;
    while (pops < target && n < budget) begin
      cyc(1);
      if (alt_ready) bus.m_ready = ~bus.m_ready;
      n++;
    end
    chk(tag, pops, target);
  endtask

  initial begin
    logic [11:0] re_hist, v_hist;
    int r0, p0, loaded;

    bus.fifo_empty = 1'b0;  // FIFO claims data during reset: no read may issue
    bus.m_ready    = 1'b1;
    cyc(4);
    bus.fifo_empty = 1'b1;
    rst = 1'b1;
    cyc(2);

    // streaming: 8 words back to back
    for (int i = 1; i <= 8; i++) push(FW'(i * 8'h11));
    re_hist = '0;
    v_hist  = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      re_hist[i] = bus.read_enable;
      v_hist[i]  = bus.m_valid;
      cyc(1);
    end
    chk("stream_read_enable_run", re_hist, 12'h0FF);
    chk("stream_m_valid_run", v_hist, 12'h3FC);
    chk("stream_words_read", bus.words_read, exp_cnt(8));

    // backpressure: only two reads while stalled, head held at 0x11
    bus.m_ready = 1'b0;
    r0 = reads;
    p0 = pops;
    for (int i = 1; i <= 8; i++) push(FW'(i * 8'h11));
    cyc(8);
    chk("bp_reads", reads - r0, 2);
    chk("bp_head", bus.m_data, 8'h11);
    bus.m_ready = 1'b1;
    drain_until("bp_drain", p0 + 8, 40, 1'b0);

    // alternating ready with bursty random arrivals
    p0 = pops;
    loaded = 0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 60 && pops < p0 + 16; i++) begin
      cyc(1);
      bus.m_ready = ~bus.m_ready;
      if (loaded < 16 && $urandom_range(0, 2) != 0) begin
        push(FW'($urandom));
        loaded++;
      end
    end
    chk("alt_loaded", loaded, 16);
    drain_until("alt_drain", p0 + 16, 40, 1'b1);

    // fully random ready and arrivals
    p0 = pops;
    loaded = 0;
    for (int i = 0; i < 200 && pops < p0 + 24; i++) begin
      cyc(1);
      bus.m_ready = 1'($urandom_range(0, 1));
      if (loaded < 24 && $urandom_range(0, 1) != 0) begin
        push(FW'($urandom));
        loaded++;
      end
    end
    bus.m_ready = 1'b1;
    chk("rand_loaded", loaded, 24);
    drain_until("rand_drain", p0 + 24, 40, 1'b0);

    // reset mid-stream with two words buffered
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(FW'(8'hC0 + i));
    cyc(4);
    chk("pre_rst_m_valid", bus.m_valid, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    fq.delete();
    #1;
    chk("async_rst_m_valid", bus.m_valid, 0);
    chk("async_rst_words_read", bus.words_read, 0);
    chk("async_rst_read_enable", bus.read_enable, 0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    bus.m_ready = 1'b1;
    drain_until("post_rst_drain", 3, 20, 1'b0);
    chk("post_rst_words_read", bus.words_read, exp_cnt(3));

    // counter wrap at 2^CW accepts
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    for (int i = 0; i < 16; i++) push(FW'($urandom));
    drain_until("wrap_drain", 16, 40, 1'b0);
    chk("wrap_words_read", bus.words_read, 0);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
